// File: rtl/arm_sequencer.sv
// Arm/disarm stick-gesture sequencer with radio-loss failsafe for the ESC enable path.
// Optional idle auto-disarm is compiled in with `define ARM_SEQ_AUTO_DISARM_EN.
module arm_sequencer #(
  parameter logic [9:0] LO_THR        = 10'd100,
  parameter logic [9:0] HI_THR        = 10'd900,
  parameter int         HOLD_TICKS    = 1000,
  parameter int         TIMEOUT_TICKS = 100,
  parameter int         IDLE_TICKS    = 10000,
  parameter int         CNT_W         = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic [39:0] radio_val,
  input  logic        radio_valid,
  output logic        armed,
  output logic        arming,
  output logic        failsafe,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ST_DISARMED    = 3'd0,
    ST_ARM_HOLD    = 3'd1,
    ST_ARMED       = 3'd2,
    ST_DISARM_HOLD = 3'd3,
    ST_FAILSAFE    = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_TICKS);
  localparam logic [CNT_W-1:0] TO_MAX   = CNT_W'(TIMEOUT_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [9:0]       thr_q, thr_d, yaw_q, yaw_d;
  logic [CNT_W-1:0] hold_q, hold_d, to_q, to_d, hold_inc;
  logic             arm_g, disarm_g, thr_low, lost;

  // Roll/pitch are carried on the bus but play no part in the gestures.
  logic unused_inputs;
  assign unused_inputs = ^{radio_val[19:0], CNT_W'(IDLE_TICKS)};

  assign thr_low  = thr_q < LO_THR;
  assign arm_g    = thr_low && (yaw_q > HI_THR);
  assign disarm_g = thr_low && (yaw_q < LO_THR);

  always_comb begin
    thr_d = thr_q;
    yaw_d = yaw_q;
    to_d  = to_q;
    if (radio_valid) begin
      thr_d = radio_val[29:20];
      yaw_d = radio_val[39:30];
      to_d  = '0;
    end else if (tick && (to_q != TO_MAX)) begin
      to_d = to_q + CNT_ONE;
    end
    // Looking at the next count makes failsafe land on the same edge the timeout expires.
    lost = (to_d == TO_MAX);
  end

`ifdef ARM_SEQ_AUTO_DISARM_EN
  localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_TICKS);
  logic [CNT_W-1:0] idle_q, idle_d;
`endif

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    hold_inc = hold_q + CNT_ONE;
`ifdef ARM_SEQ_AUTO_DISARM_EN
    idle_d   = idle_q;
`endif
    case (state_q)
      ST_DISARMED: begin
        if (tick && arm_g) begin
          state_d = (CNT_ONE == HOLD_MAX) ? ST_ARMED : ST_ARM_HOLD;
          hold_d  = (CNT_ONE == HOLD_MAX) ? '0 : CNT_ONE;
        end
      end
      ST_ARM_HOLD: begin
        if (tick) begin
          if (!arm_g) begin
            state_d = ST_DISARMED;
            hold_d  = '0;
          end else if (hold_inc == HOLD_MAX) begin
            state_d = ST_ARMED;
            hold_d  = '0;
          end else begin
            hold_d = hold_inc;
          end
        end
      end
      ST_ARMED: begin
        if (tick && disarm_g) begin
          state_d = (CNT_ONE == HOLD_MAX) ? ST_DISARMED : ST_DISARM_HOLD;
          hold_d  = (CNT_ONE == HOLD_MAX) ? '0 : CNT_ONE;
        end
`ifdef ARM_SEQ_AUTO_DISARM_EN
        if (tick) begin
          idle_d = thr_low ? (idle_q + CNT_ONE) : '0;
          if (idle_d == IDLE_MAX) begin
            state_d = ST_DISARMED;
            hold_d  = '0;
          end
        end
`endif
      end
      ST_DISARM_HOLD: begin
        if (tick) begin
          if (!disarm_g) begin
            state_d = ST_ARMED;
            hold_d  = '0;
          end else if (hold_inc == HOLD_MAX) begin
            state_d = ST_DISARMED;
            hold_d  = '0;
          end else begin
            hold_d = hold_inc;
          end
        end
      end
      ST_FAILSAFE: begin
        hold_d = '0;
        if (radio_valid && (radio_val[29:20] < LO_THR)) state_d = ST_DISARMED;
      end
      default: begin
        state_d = ST_FAILSAFE;
        hold_d  = '0;
      end
    endcase

    if (lost) begin
      state_d = ST_FAILSAFE;
      hold_d  = '0;
    end
`ifdef ARM_SEQ_AUTO_DISARM_EN
    // The idle count survives a disarm hold so a bounced gesture cannot reset it.
    if ((state_d != ST_ARMED) && (state_d != ST_DISARM_HOLD)) idle_d = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FAILSAFE;
      thr_q   <= '0;
      yaw_q   <= '0;
      hold_q  <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      thr_q   <= thr_d;
      yaw_q   <= yaw_d;
      hold_q  <= hold_d;
      to_q    <= to_d;
    end
  end

`ifdef ARM_SEQ_AUTO_DISARM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`endif

  assign armed    = (state_q == ST_ARMED) || (state_q == ST_DISARM_HOLD);
  assign arming   = (state_q == ST_ARM_HOLD) || (state_q == ST_DISARM_HOLD);
  assign failsafe = (state_q == ST_FAILSAFE);
  assign state    = state_q;

endmodule
